can_tx_frame_loader: RTL
========================

CAN_TX_FRAME_LOADER -- requirements
Module: can_tx_frame_loader

Interface
REQ-001 SHALL have parameter CMD_ADDR, default 8'd1, the controller command register address.
REQ-002 SHALL have parameter TR_CMD, default 8'h01, the transmission-request command value.
REQ-003 SHALL have ports clk_i in 1, the only clock; reg_rst_i in 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid_i in 1, frame request valid.
REQ-005 SHALL have port req_ready_o out 1, loader can accept a request.
REQ-006 SHALL have ports req_ide_i in 1 (1 = 29-bit ID) and req_rtr_i in 1 (remote frame).
REQ-007 SHALL have ports req_id_i in 29 (standard ID in [10:0]) and req_dlc_i in 4.
REQ-008 SHALL have port req_data_i in 64; data byte k = [8k+7:8k], byte 0 sent first.
REQ-009 SHALL have port tx_buf_free_i in 1, controller TX buffer released (status TBS).
REQ-010 SHALL have ports tx_we_o out 1, tx_addr_o out 4 and tx_data_o out 8, the controller TX buffer write port.
REQ-011 SHALL have ports reg_we_o out 1, reg_addr_write_o out 8 and reg_data_o out 8, the controller register write port.
REQ-012 SHALL have ports busy_o out 1 (not IDLE) and done_o out 1 (one-cycle completion pulse).

Function
REQ-013 SHALL implement states IDLE, WAIT_BUF, WR_INFO, WR_ID, WR_DATA, WR_CMD and DONE.
REQ-014 req_ready_o SHALL be 1 only in IDLE; a handshake is req_valid_i & req_ready_o at a rising edge.
REQ-015 On handshake, SHALL register ide, rtr, id, dlc and data, then go to WAIT_BUF; later input changes SHALL be ignored.
REQ-016 WAIT_BUF SHALL stay while tx_buf_free_i=0 and go to WR_INFO on the edge where it is 1.
REQ-017 Each write state SHALL issue exactly one tx_we_o=1 cycle per byte, one byte per cycle, with no gaps.
REQ-018 WR_INFO SHALL write addr 0 = {ide, rtr, 2'b00, dlc}, with dlc passed through unclamped.
REQ-019 WR_ID, standard frame, SHALL write addr 1 = id[10:3] and addr 2 = {id[2:0], 5'b0}.
REQ-020 WR_ID, extended frame, SHALL write addr 1..4 = id[28:21], id[20:13], id[12:5], {id[4:0], 3'b0}.
REQ-021 Data byte count N SHALL be 0 if rtr=1, else min(dlc, 8).
REQ-022 WR_DATA SHALL write data byte k to addr base+k (base 3 standard, 5 extended) for k = 0..N-1 and be skipped when N=0.
REQ-023 WR_CMD SHALL pulse reg_we_o for one cycle with reg_addr_write_o=CMD_ADDR and reg_data_o=TR_CMD.
REQ-024 DONE SHALL assert done_o for one cycle, then go to IDLE; req_ready_o returns 1 the next cycle.
REQ-025 Frame sequence length SHALL be 1 + (2 or 4) + N TX writes, then exactly 1 register write.
REQ-026 tx_we_o and reg_we_o SHALL never be 1 in the same cycle.
REQ-027 Outside its active write cycle, tx_addr_o, tx_data_o, reg_addr_write_o and reg_data_o SHALL be 0.
REQ-028 tx_buf_free_i SHALL be sampled only in WAIT_BUF; a drop to 0 mid-load SHALL NOT stall the sequence.

Reset
REQ-029 With reg_rst_i=1 at a rising edge: state to IDLE, captured fields cleared, all write strobes, busy_o and done_o 0.
REQ-030 After that edge req_ready_o SHALL be 1.
REQ-031 Reset mid-sequence SHALL abort without issuing the command write; no partial strobe SHALL follow the reset edge.

Verification
REQ-032 Standard ID 0x123, dlc 2, data AA,55, buf free -> TX writes 0:02, 1:24, 2:60, 3:AA, 4:55 on consecutive cycles, then reg 01<=01, then done_o pulse.
REQ-033 Extended ID 0x1ABCDEF5, dlc 8 -> TX writes 0:88, 1:D5, 2:E6, 3:F7, 4:A8, 5..12 data bytes 0..7, then command write.
REQ-034 Standard RTR, dlc 4 -> TX writes 0:44, 1, 2 only, then command write; no data writes.
REQ-035 Non-RTR dlc 15 -> info byte 0x0F, exactly 8 data writes (addr 3..10).
REQ-036 tx_buf_free_i=0 for 20 cycles after handshake -> no strobes, busy_o=1, req_ready_o=0; first write one cycle after it rises.
REQ-037 reg_rst_i=1 during WR_DATA -> strobes 0 from that edge, no command write, req_ready_o=1; a new request completes normally.

Source files
------------

// File: rtl/can_tx_frame_loader.sv
// CAN TX frame loader: captures one frame request, waits for the controller
// TX buffer to be released, writes the frame info, ID and data bytes into the
// buffer one per cycle, then issues the transmission-request command.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | ready for a new request
// WAIT_BUF | request captured, waiting for tx_buf_free_i
// WR_INFO  | writing frame info byte (addr 0)
// WR_ID    | writing 2 (standard) or 4 (extended) ID bytes
// WR_DATA  | writing N data bytes, skipped when N = 0
// WR_CMD   | single command register write
// DONE     | one-cycle completion pulse
module can_tx_frame_loader #(
  parameter logic [7:0] CMD_ADDR = 8'd1,
  parameter logic [7:0] TR_CMD   = 8'h01
) (
  input  logic        clk_i,
  input  logic        reg_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_ide_i,
  input  logic        req_rtr_i,
  input  logic [28:0] req_id_i,
  input  logic [3:0]  req_dlc_i,
  input  logic [63:0] req_data_i,
  input  logic        tx_buf_free_i,
  output logic        tx_we_o,
  output logic [3:0]  tx_addr_o,
  output logic [7:0]  tx_data_o,
  output logic        reg_we_o,
  output logic [7:0]  reg_addr_write_o,
  output logic [7:0]  reg_data_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE, WAIT_BUF, WR_INFO, WR_ID, WR_DATA, WR_CMD, DONE
  } state_t;

  state_t      state_q, state_next;
  logic        ide_q, rtr_q;
  logic [28:0] id_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic [3:0]  cnt_q;
  logic [3:0]  n_bytes;
  logic [3:0]  id_last;
  logic [3:0]  data_base;

  // RTR frames carry no payload; DLC values above 8 still mean 8 bytes.
  assign n_bytes   = rtr_q ? 4'd0 : ((dlc_q > 4'd8) ? 4'd8 : dlc_q);
  assign id_last   = ide_q ? 4'd3 : 4'd1;
  assign data_base = ide_q ? 4'd5 : 4'd3;

  // State register.
  always_ff @(posedge clk_i) begin
    if (reg_rst_i) state_q <= IDLE;
    else           state_q <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:     if (req_valid_i)   state_next = WAIT_BUF;
      WAIT_BUF: if (tx_buf_free_i) state_next = WR_INFO;
      WR_INFO:  state_next = WR_ID;
      WR_ID:    if (cnt_q == id_last)
                  state_next = (n_bytes == 4'd0) ? WR_CMD : WR_DATA;
      WR_DATA:  if (cnt_q == n_bytes - 4'd1) state_next = WR_CMD;
      WR_CMD:   state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Capture the request fields at the handshake; later input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (reg_rst_i) begin
      ide_q  <= 1'b0;
      rtr_q  <= 1'b0;
      id_q   <= '0;
      dlc_q  <= '0;
      data_q <= '0;
    end else if (state_q == IDLE && req_valid_i) begin
      ide_q  <= req_ide_i;
      rtr_q  <= req_rtr_i;
      id_q   <= req_id_i;
      dlc_q  <= req_dlc_i;
      data_q <= req_data_i;
    end
  end

  // Byte index within WR_ID / WR_DATA; restarts at 0 on every state change.
  always_ff @(posedge clk_i) begin
    if (reg_rst_i)                     cnt_q <= '0;
    else if (state_next != state_q)    cnt_q <= '0;
    else if (state_q == WR_ID || state_q == WR_DATA) cnt_q <= cnt_q + 4'd1;
  end

  // Output decode; write buses are held at zero outside their strobe cycle.
  always_comb begin
    req_ready_o      = (state_q == IDLE);
    busy_o           = (state_q != IDLE);
    done_o           = 1'b0;
    tx_we_o          = 1'b0;
    tx_addr_o        = 4'd0;
    tx_data_o        = 8'd0;
    reg_we_o         = 1'b0;
    reg_addr_write_o = 8'd0;
    reg_data_o       = 8'd0;
    case (state_q)
      WR_INFO: begin
        tx_we_o   = 1'b1;
        tx_addr_o = 4'd0;
        tx_data_o = {ide_q, rtr_q, 2'b00, dlc_q};
      end
      WR_ID: begin
        tx_we_o   = 1'b1;
        tx_addr_o = 4'd1 + cnt_q;
        case ({ide_q, cnt_q[1:0]})
          3'b000:  tx_data_o = id_q[10:3];
          3'b001:  tx_data_o = {id_q[2:0], 5'b0};
          3'b100:  tx_data_o = id_q[28:21];
          3'b101:  tx_data_o = id_q[20:13];
          3'b110:  tx_data_o = id_q[12:5];
          3'b111:  tx_data_o = {id_q[4:0], 3'b0};
          default: tx_data_o = 8'd0;
        endcase
      end
      WR_DATA: begin
        tx_we_o   = 1'b1;
        tx_addr_o = data_base + cnt_q;
        tx_data_o = data_q[{cnt_q[2:0], 3'b000} +: 8];
      end
      WR_CMD: begin
        reg_we_o         = 1'b1;
        reg_addr_write_o = CMD_ADDR;
        reg_data_o       = TR_CMD;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
